// File: rtl/dmem_mmio_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus a small MMIO block
// holding a byte output FIFO and a down-counting timer with a sticky expiry flag.
module dmem_mmio_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] memDataAddr,
    input  logic [31:0] memWriteData,
    output logic [31:0] memReadData,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES    = 32'(RAM_WORDS * 4);
    localparam logic [31:0] ADDR_STATUS  = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_TXDATA  = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_TMRCNT  = 32'hFFFF_FF08;
    localparam logic [31:0] ADDR_TMRCTRL = 32'hFFFF_FF0C;

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [PW:0]   fifoCount;
    logic          overflow;
    logic [31:0]   timerCount;
    logic          timerEnable;
    logic          expired;

    logic          ramHit;
    logic          hitStatus;
    logic          hitTx;
    logic          hitCnt;
    logic          hitCtrl;
    logic [AW-1:0] ramIdx;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          pop;
    logic          pushOk;
    logic          pushDrop;
    logic          cntWrite;
    logic          ctrlWrite;
    logic          tick;
    logic          expireNow;
    logic [31:0]   statusWord;

    assign ramHit    = memDataAddr < RAM_BYTES;
    assign hitStatus = memDataAddr == ADDR_STATUS;
    assign hitTx     = memDataAddr == ADDR_TXDATA;
    assign hitCnt    = memDataAddr == ADDR_TMRCNT;
    assign hitCtrl   = memDataAddr == ADDR_TMRCTRL;
    assign ramIdx    = memDataAddr[AW+1:2];

    assign fifoEmpty = fifoCount == '0;
    assign fifoFull  = fifoCount == (PW+1)'(FIFO_DEPTH);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign pushOk    = memWrite & hitTx & (~fifoFull | pop);
    assign pushDrop  = memWrite & hitTx & fifoFull & ~pop;

    assign cntWrite  = memWrite & hitCnt;
    assign ctrlWrite = memWrite & hitCtrl;
    assign tick      = timerEnable & (timerCount != '0);
    assign expireNow = ~cntWrite & tick & (timerCount == 32'd1);

    assign out_valid = ~fifoEmpty;
    assign out_data  = out_valid ? fifoMem[rdPtr] : 8'h00;
    assign timer_irq = expired;

    always_comb begin
        statusWord      = '0;
        statusWord[8:4] = 5'(fifoCount);
        statusWord[3:0] = {expired, overflow, fifoFull, fifoEmpty};
    end

    always_comb begin
        memReadData = '0;
        if (ramHit)
            memReadData = ram[ramIdx];
        else if (hitStatus)
            memReadData = statusWord;
        else if (hitCnt)
            memReadData = timerCount;
        else if (hitCtrl)
            memReadData = {31'b0, timerEnable};
    end

    // Storage arrays carry no reset; FIFO slots are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (memWrite && ramHit)
            ram[ramIdx] <= memWriteData;
        if (pushOk)
            fifoMem[wrPtr] <= memWriteData[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pushOk)
                wrPtr <= wrPtr + PW'(1);
            if (pop)
                rdPtr <= rdPtr + PW'(1);
            if (pushOk && !pop)
                fifoCount <= fifoCount + (PW+1)'(1);
            else if (pop && !pushOk)
                fifoCount <= fifoCount - (PW+1)'(1);
            if (pushDrop)
                overflow <= 1'b1;
            else if (memWrite && hitStatus && memWriteData[2])
                overflow <= 1'b0;
        end
    end

    // A count load beats the decrement; an expiry beats a clear landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timerCount  <= '0;
            timerEnable <= 1'b0;
            expired     <= 1'b0;
        end else begin
            if (cntWrite)
                timerCount <= memWriteData;
            else if (tick)
                timerCount <= timerCount - 32'd1;
            if (ctrlWrite)
                timerEnable <= memWriteData[0];
            if (expireNow)
                expired <= 1'b1;
            else if (ctrlWrite && memWriteData[1])
                expired <= 1'b0;
        end
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-side bus responder for the single-cycle MIPS core. It sits on the core's data memory port in place of the plain data RAM.
- It decodes each access into a word RAM region or a small memory-mapped I/O region.
- The I/O region holds a byte output FIFO, drained over a valid/ready stream, and a down-counting timer with a sticky expiry flag.
- Reads are combinational so the core completes a load in one cycle; all state updates occur on the rising clock edge.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, at most 1024.
- FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memWrite  input  1  core store strobe for the current cycle.
- memDataAddr  input  32  byte address from the core ALU output.
- memWriteData  input  32  store data from the core.
- memReadData  output  32  load data to the core; combinational.
- out_data  output  8  head byte of the FIFO.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- timer_irq  output  1  copy of the sticky expired flag.

Behaviour:
- Address decode:
  - RAM region: address < RAM_WORDS*4. Word index is addr[log2(RAM_WORDS)+1:2]; addr[1:0] is ignored.
  - MMIO region: addresses 0xFFFF_FF00..0xFFFF_FF0C, word-aligned, as listed below.
  - Any other address: reads return 0; writes have no effect.
- STATUS, 0xFFFF_FF00, read-only:
  - bit0 empty, bit1 full, bit2 overflow sticky, bit3 expired sticky.
  - bits[8:4] FIFO count; all other bits 0.
  - A write of 1 to bit2 clears overflow.
- TXDATA, 0xFFFF_FF04:
  - Write pushes memWriteData[7:0] into the FIFO.
  - Read returns 0.
- TIMER_CNT, 0xFFFF_FF08:
  - Write loads the 32-bit count.
  - Read returns the current count.
- TIMER_CTRL, 0xFFFF_FF0C:
  - Write: bit0 sets the enable value; bit1 = 1 clears expired.
  - Read: bit0 enable, other bits 0.
- RAM:
  - Write on the clock edge when memWrite is high and the address hits RAM.
  - Read is combinational: the word at the current index.
  - Contents are not cleared by reset (initial value undefined).
- FIFO:
  - pop = out_valid & out_ready.
  - push = memWrite & address hits TXDATA.
  - A push is accepted when not full, or when full and pop occurs in the same cycle.
  - A push that is not accepted drops the byte and sets overflow.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is valid only while out_valid is high and must hold stable until popped.
- Timer:
  - While enable is set and count != 0, count decrements by 1 per cycle.
  - On the cycle count goes 1 -> 0, expired is set.
  - When count reaches 0 it holds at 0; expired does not re-set while count stays 0.
  - A TIMER_CNT write takes priority over the decrement in the same cycle.
  - Loading 0 does not set expired.
  - If an expiry and a clear land in the same cycle, the set wins.
- Reset (asynchronous, reset = 0):
  - FIFO empty, pointers 0, overflow = 0.
  - count = 0, enable = 0, expired = 0.
  - out_valid = 0, timer_irq = 0, out_data = 0.
  - memReadData reflects the reset state on MMIO reads.
  - Reset asserted mid-stream discards FIFO contents immediately.
- Latency:
  - Load data is available in the same cycle.
  - A store is visible to reads from the following cycle.
  - A pushed byte appears on out_valid in the cycle after the push.

Test Plan:
1. RAM access:
   - Stimulus: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013.
   - Response: both loads return 0xDEADBEEF; a load of unmapped 0x0000_1000 returns 0.
2. FIFO order and status:
   - Stimulus: out_ready = 0; push 0x41, 0x42, 0x43, 0x44.
   - Response: STATUS = 0x42 (count 4, full). A fifth push of 0x45 is dropped and STATUS reads 0x46. With out_ready = 1, bytes leave in order 0x41..0x44, then out_valid = 0.
3. Push and pop when full:
   - Stimulus: FIFO full, out_ready = 1, push 0x55 in the same cycle.
   - Response: count stays 4, overflow is not set, and 0x55 is the last byte drained.
4. Timer expiry:
   - Stimulus: write TIMER_CNT = 3, then TIMER_CTRL = 1.
   - Response: count reads 2, 1, 0 on consecutive cycles. timer_irq rises in the cycle count hits 0 and stays high. Writing TIMER_CTRL = 0x2 clears it.
5. Timer priority:
   - Stimulus: write TIMER_CNT = 10 in the same cycle the timer would reach 0.
   - Response: count = 10 and expired stays 0.
6. Asynchronous reset:
   - Stimulus: assert reset = 0 between clock edges while the FIFO holds 2 bytes and the timer is running.
   - Response: out_valid, timer_irq and count read 0 immediately. After release, STATUS reads 0x1.
